// File: rtl/uart_pkg.sv
// uart_pkg -- constants and helpers shared by the UART transmitter and receiver.
//   PARITY_*      : encoding of the PARITY parameter (none / even / odd)
//   ST_*          : transmitter FSM state encoding
//   clks_per_bit  : system clocks per line bit, integer-truncated
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int clks_per_bit(input int sys_clock, input int baudrate);
    return sys_clock / baudrate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with first-word-fall-through read data.
//   i_Clock, i_Reset : clock, asynchronous active-high reset (empties the FIFO)
//   i_Push, i_Data   : write request and word; ignored while full
//   i_Pop            : read request; ignored while empty
//   o_Data           : word at the head of the FIFO (valid when !o_Empty)
//   o_Full, o_Empty  : occupancy flags
//   o_Count          : occupied entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_Data,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [AW-1:0]    r_WrPtr;
  logic [AW-1:0]    r_RdPtr;
  logic [AW:0]      r_Count;
  logic             w_DoPush;
  logic             w_DoPop;

  assign w_DoPush = i_Push && !o_Full;
  assign w_DoPop  = i_Pop && !o_Empty;

  // Pointers are exactly AW bits wide, so incrementing wraps modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_WrPtr <= '0;
      r_RdPtr <= '0;
      r_Count <= '0;
    end else begin
      if (w_DoPush) r_WrPtr <= r_WrPtr + 1'b1;
      if (w_DoPop)  r_RdPtr <= r_RdPtr + 1'b1;
      case ({w_DoPush, w_DoPop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count need
  // one, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge i_Clock) begin
    if (w_DoPush) r_Mem[r_WrPtr] <= i_Data;
  end

  assign o_Data  = r_Mem[r_RdPtr];
  assign o_Full  = (r_Count == FULL_COUNT);
  assign o_Empty = (r_Count == '0);
  assign o_Count = r_Count;

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter with a TX FIFO.
//   i_SysClock  : system clock (rising edge)
//   i_Reset     : asynchronous active-high reset; aborts any frame, line high
//   i_TxValid   : i_TxData offered this cycle; accepted when o_TxReady=1
//   i_TxData    : DATA_BITS-wide word to send (LSB first)
//   o_TxReady   : FIFO not full
//   o_TxSerial  : serial line, idle high
//   o_TxBusy    : a frame (start..stop) is in progress
//   o_TxDone    : one-cycle pulse on the last cycle of the stop period
//   o_FifoCount : occupied FIFO entries
//   o_Overflow  : one-cycle pulse when an offered word is dropped
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          i_SysClock,
  input  logic                          i_Reset,
  input  logic                          i_TxValid,
  input  logic [DATA_BITS-1:0]          i_TxData,
  output logic                          o_TxReady,
  output logic                          o_TxSerial,
  output logic                          o_TxBusy,
  output logic                          o_TxDone,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoCount,
  output logic                          o_Overflow
);

  localparam int CPB = clks_per_bit(SYS_CLOCK, UART_BAUDRATE);
  localparam int CW  = $clog2(STOP_BITS * CPB + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CPB - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic [2:0]           r_State;
  logic [CW-1:0]        r_ClkCnt;
  logic [BW-1:0]        r_BitIdx;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_ParityBit;
  logic                 r_TxSerial;

  logic [DATA_BITS-1:0] w_FifoData;
  logic                 w_Full;
  logic                 w_Empty;
  logic                 w_Pop;
  logic                 w_BitEnd;
  logic                 w_StopEnd;
  logic                 w_ParityCalc;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_SysClock),
    .i_Reset (i_Reset),
    .i_Push  (i_TxValid),
    .i_Data  (i_TxData),
    .i_Pop   (w_Pop),
    .o_Data  (w_FifoData),
    .o_Full  (w_Full),
    .o_Empty (w_Empty),
    .o_Count (o_FifoCount)
  );

  assign w_BitEnd  = (r_ClkCnt == BIT_LAST);
  assign w_StopEnd = (r_ClkCnt == STOP_LAST);

  // A word leaves the FIFO either from idle or on the very last stop cycle,
  // which is what makes back-to-back frames gapless.
  assign w_Pop = !w_Empty &&
                 ((r_State == ST_IDLE) || ((r_State == ST_STOP) && w_StopEnd));

  // Parity is fixed when the word is loaded, so the shift register can be
  // consumed freely during DATA.
  assign w_ParityCalc = (^w_FifoData) ^ (PARITY == PARITY_ODD);

  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= ST_IDLE;
      r_ClkCnt    <= '0;
      r_BitIdx    <= '0;
      r_Shift     <= '0;
      r_ParityBit <= 1'b0;
      r_TxSerial  <= 1'b1;
    end else begin
      case (r_State)
        ST_IDLE: begin
          r_TxSerial <= 1'b1;
        end
        ST_START: begin
          if (w_BitEnd) begin
            r_ClkCnt   <= '0;
            r_BitIdx   <= '0;
            r_State    <= ST_DATA;
            r_TxSerial <= r_Shift[0];
            r_Shift    <= r_Shift >> 1;
          end else begin
            r_ClkCnt <= r_ClkCnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_BitEnd) begin
            r_ClkCnt <= '0;
            if (r_BitIdx == IDX_LAST) begin
              if (PARITY != PARITY_NONE) begin
                r_State    <= ST_PARITY;
                r_TxSerial <= r_ParityBit;
              end else begin
                r_State    <= ST_STOP;
                r_TxSerial <= 1'b1;
              end
            end else begin
              r_BitIdx   <= r_BitIdx + 1'b1;
              r_TxSerial <= r_Shift[0];
              r_Shift    <= r_Shift >> 1;
            end
          end else begin
            r_ClkCnt <= r_ClkCnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_BitEnd) begin
            r_ClkCnt   <= '0;
            r_State    <= ST_STOP;
            r_TxSerial <= 1'b1;
          end else begin
            r_ClkCnt <= r_ClkCnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_StopEnd) begin
            r_ClkCnt   <= '0;
            r_State    <= ST_IDLE;
            r_TxSerial <= 1'b1;
          end else begin
            r_ClkCnt <= r_ClkCnt + 1'b1;
          end
        end
        default: begin
          r_State    <= ST_IDLE;
          r_ClkCnt   <= '0;
          r_TxSerial <= 1'b1;
        end
      endcase

      // Loading a word overrides the IDLE/STOP assignments above: start the
      // frame on this edge so the start bit appears on the next cycle.
      if (w_Pop) begin
        r_Shift     <= w_FifoData;
        r_ParityBit <= w_ParityCalc;
        r_ClkCnt    <= '0;
        r_State     <= ST_START;
        r_TxSerial  <= 1'b0;
      end
    end
  end

  assign o_TxSerial = r_TxSerial;
  assign o_TxBusy   = (r_State != ST_IDLE);
  assign o_TxDone   = (r_State == ST_STOP) && w_StopEnd;
  assign o_TxReady  = !w_Full;
  assign o_Overflow = i_TxValid && w_Full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- self-checking bench for uart_tx_cfg.
// Five instances cover defaults, even parity, odd parity with two stop bits,
// 5-bit data and a FIFO overflow burst. A behavioural line decoder rebuilds
// each frame from bit periods and compares it against the written words.
module tb_uart_tx_cfg;

  localparam int N    = 5;
  localparam int CPB0 = 50000000 / 115200;

  int cpb [N] = '{CPB0, 10, CPB0, 10, 8};
  int db  [N] = '{8, 8, 8, 5, 8};
  int par [N] = '{0, 1, 2, 0, 0};
  int stp [N] = '{1, 1, 2, 1, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid  [N];
  logic [8:0] data   [N];
  logic       ready  [N];
  logic       serial [N];
  logic       busy   [N];
  logic       done   [N];
  logic       ovf    [N];
  logic [4:0] fcount [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg u0 (
    .i_SysClock(clk), .i_Reset(rst), .i_TxValid(valid[0]), .i_TxData(data[0][7:0]),
    .o_TxReady(ready[0]), .o_TxSerial(serial[0]), .o_TxBusy(busy[0]),
    .o_TxDone(done[0]), .o_FifoCount(fcount[0]), .o_Overflow(ovf[0]));

  uart_tx_cfg #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .PARITY(1)) u1 (
    .i_SysClock(clk), .i_Reset(rst), .i_TxValid(valid[1]), .i_TxData(data[1][7:0]),
    .o_TxReady(ready[1]), .o_TxSerial(serial[1]), .o_TxBusy(busy[1]),
    .o_TxDone(done[1]), .o_FifoCount(fcount[1]), .o_Overflow(ovf[1]));

  uart_tx_cfg #(.PARITY(2), .STOP_BITS(2)) u2 (
    .i_SysClock(clk), .i_Reset(rst), .i_TxValid(valid[2]), .i_TxData(data[2][7:0]),
    .o_TxReady(ready[2]), .o_TxSerial(serial[2]), .o_TxBusy(busy[2]),
    .o_TxDone(done[2]), .o_FifoCount(fcount[2]), .o_Overflow(ovf[2]));

  uart_tx_cfg #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .DATA_BITS(5)) u3 (
    .i_SysClock(clk), .i_Reset(rst), .i_TxValid(valid[3]), .i_TxData(data[3][4:0]),
    .o_TxReady(ready[3]), .o_TxSerial(serial[3]), .o_TxBusy(busy[3]),
    .o_TxDone(done[3]), .o_FifoCount(fcount[3]), .o_Overflow(ovf[3]));

  uart_tx_cfg #(.SYS_CLOCK(800000), .UART_BAUDRATE(100000), .FIFO_DEPTH(16)) u4 (
    .i_SysClock(clk), .i_Reset(rst), .i_TxValid(valid[4]), .i_TxData(data[4][7:0]),
    .o_TxReady(ready[4]), .o_TxSerial(serial[4]), .o_TxBusy(busy[4]),
    .o_TxDone(done[4]), .o_FifoCount(fcount[4]), .o_Overflow(ovf[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Offer one word for exactly one clock edge; call on a negedge.
  task automatic push(input int k, input logic [8:0] w);
    valid[k] = 1'b1;
    data[k]  = w;
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  // Receive one frame on instance k. The start bit must appear within
  // max_wait negedges. The frame is cut into bit periods of cpb cycles:
  // start must be 0, stop periods 1, data/parity periods stable. Returns at
  // the negedge of the frame's last cycle.
  task automatic rx_frame(input int k, input int max_wait,
                          output logic [8:0] d, output logic pbit);
    int   w, total, nseg_pre, seg, ph;
    int   bad_fixed, glitch, done_last, done_extra, not_busy;
    logic ref_v;
    d = '0; pbit = 1'b0; ref_v = 1'b0;
    w = 0; bad_fixed = 0; glitch = 0; done_last = 0; done_extra = 0; not_busy = 0;
    do begin
      @(negedge clk);
      w++;
    end while (serial[k] !== 1'b0 && w < max_wait);
    check("rx_start_seen", serial[k], 1'b0);
    if (serial[k] !== 1'b0) return;
    nseg_pre = 1 + db[k] + ((par[k] != 0) ? 1 : 0);
    total    = (nseg_pre + stp[k]) * cpb[k];
    for (int t = 0; t < total; t++) begin
      if (t > 0) @(negedge clk);
      seg = t / cpb[k];
      ph  = t % cpb[k];
      if (seg == 0) begin
        if (serial[k] !== 1'b0) bad_fixed++;
      end else if (seg >= nseg_pre) begin
        if (serial[k] !== 1'b1) bad_fixed++;
      end else if (ph == 0) begin
        ref_v = serial[k];
        if (seg <= db[k]) d = d | (9'(ref_v) << (seg - 1));
        else              pbit = ref_v;
      end else if (serial[k] !== ref_v) begin
        glitch++;
      end
      if (done[k] === 1'b1) begin
        if (t == total - 1) done_last = 1;
        else                done_extra++;
      end
      if (busy[k] !== 1'b1) not_busy++;
    end
    check("rx_start_stop_level", bad_fixed, 0);
    check("rx_bit_stable", glitch, 0);
    check("rx_done_last_cycle", done_last, 1);
    check("rx_done_extra", done_extra, 0);
    check("rx_busy_in_frame", not_busy, 0);
  endtask

  logic [7:0] exp_q[$];
  int         n_acc = 0;

  initial begin
    logic [8:0] d, w;
    logic       p;
    int         lows, dones;
    for (int k = 0; k < N; k++) begin
      valid[k] = 1'b0;
      data[k]  = '0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("rst_serial", serial[k], 1'b1);
      check("rst_busy", busy[k], 1'b0);
      check("rst_done", done[k], 1'b0);
      check("rst_ovf", ovf[k], 1'b0);
      check("rst_count", fcount[k], 0);
      check("rst_ready", ready[k], 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Defaults, 0x55: bits 1,0,1,0,... LSB first, 434 clocks each.
    push(0, 9'h055);
    rx_frame(0, 2, d, p);
    check("u0_data_55", d, 9'h055);

    // Even parity.
    push(1, 9'h007);
    rx_frame(1, 2, d, p);
    check("u1_data_07", d, 9'h007);
    check("u1_even_par_07", p, 1'b1);
    for (int i = 0; i < 6; i++) begin
      w = 9'($urandom_range(0, 255));
      push(1, w);
      rx_frame(1, 2, d, p);
      check("u1_data_rand", d, w);
      check("u1_even_par_rand", p, ^w[7:0]);
    end

    // Odd parity, two stop bits (stop period 868 clocks).
    push(2, 9'h007);
    rx_frame(2, 2, d, p);
    check("u2_data_07", d, 9'h007);
    check("u2_odd_par_07", p, 1'b0);
    w = 9'($urandom_range(0, 255));
    push(2, w);
    rx_frame(2, 2, d, p);
    check("u2_data_rand", d, w);
    check("u2_odd_par_rand", p, ~^w[7:0]);

    // 5 data bits: 7 bit times, bits above DATA_BITS never transmitted.
    push(3, 9'h01F);
    rx_frame(3, 2, d, p);
    check("u3_data_1f", d, 9'h01F);
    for (int i = 0; i < 4; i++) begin
      w = 9'($urandom_range(0, 511));
      push(3, w);
      rx_frame(3, 2, d, p);
      check("u3_data_rand", d, {4'b0, w[4:0]});
    end

    // Burst of 20 writes into a depth-16 FIFO while the transmitter runs.
    fork
      begin : burst_drv
        int cnt;
        logic [7:0] bw;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
          bw = 8'($urandom);
          valid[4] = 1'b1;
          data[4]  = {1'b0, bw};
          #1;
          check("burst_ready", ready[4], cnt < 16);
          check("burst_count", fcount[4], cnt);
          check("burst_overflow", ovf[4], cnt >= 16);
          if (cnt < 16) begin
            exp_q.push_back(bw);
            n_acc++;
            cnt++;
          end
          // The idle transmitter takes the first word on the second edge.
          if (i == 1) cnt--;
          @(negedge clk);
        end
        valid[4] = 1'b0;
        #1 check("burst_count_end", fcount[4], cnt);
      end
      begin : burst_rx
        logic [8:0] d4;
        logic       p4;
        int         n, idle_busy;
        n = 0;
        do begin
          rx_frame(4, (n == 0) ? 4 : 1, d4, p4);
          check("burst_q_nonempty", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("burst_data", d4, {1'b0, exp_q.pop_front()});
          n++;
        end while (n < n_acc);
        check("burst_accepted", n_acc, 17);
        idle_busy = 0;
        repeat (200) begin
          @(negedge clk);
          if (busy[4] !== 1'b0) idle_busy++;
        end
        check("burst_idle_after", idle_busy, 0);
      end
    join

    // Reset in the middle of a DATA bit (data 0x00 keeps the line low).
    push(0, 9'h000);
    push(0, 9'h03C);
    repeat (CPB0 * 3) @(negedge clk);
    check("abort_pre_line", serial[0], 1'b0);
    check("abort_pre_count", fcount[0], 1);
    #3 rst = 1'b1;
    #1;
    check("abort_line_high", serial[0], 1'b1);
    check("abort_busy", busy[0], 1'b0);
    check("abort_done", done[0], 1'b0);
    check("abort_count", fcount[0], 0);
    check("abort_ready", ready[0], 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    dones = 0;
    repeat (1000) begin
      @(negedge clk);
      if (serial[0] !== 1'b1) lows++;
      if (done[0] !== 1'b0) dones++;
    end
    check("abort_quiet_line", lows, 0);
    check("abort_quiet_done", dones, 0);
    push(0, 9'h0A5);
    rx_frame(0, 2, d, p);
    check("abort_recover_a5", d, 9'h0A5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter SYS_CLOCK, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUDRATE, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 and 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning TX buffer entries; power of 2, at least 2.
REQ-007 SHALL have port i_SysClock, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-008 SHALL have port i_Reset, input, 1, meaning asynchronous active-high reset.
REQ-009 SHALL have port i_TxValid, input, 1, meaning a byte is offered on i_TxData this cycle.
REQ-010 SHALL have port i_TxData, input, DATA_BITS, meaning the word to transmit.
REQ-011 SHALL have port o_TxReady, output, 1, meaning the FIFO is not full.
REQ-012 SHALL have port o_TxSerial, output, 1, meaning the serial line, idle high.
REQ-013 SHALL have port o_TxBusy, output, 1, meaning a frame is in progress.
REQ-014 SHALL have port o_TxDone, output, 1, meaning a one-cycle pulse at frame end.
REQ-015 SHALL have port o_FifoCount, output, clog2(FIFO_DEPTH)+1, meaning occupied FIFO entries.
REQ-016 SHALL have port o_Overflow, output, 1, meaning a one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL use bit time CLKS_PER_BIT = SYS_CLOCK / UART_BAUDRATE, integer-truncated (434 at the defaults).
REQ-018 SHALL push i_TxData into the FIFO in any cycle with i_TxValid=1 and o_TxReady=1.
REQ-019 SHALL drop the write and pulse o_Overflow for that cycle when i_TxValid=1 and o_TxReady=0, including a full FIFO that pops in the same cycle.
REQ-020 SHALL update o_FifoCount one cycle after a push or pop, and leave it unchanged on a simultaneous push and pop.
REQ-021 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-022 IDLE: o_TxSerial=1 and o_TxBusy=0; when the FIFO is non-empty, pop one word into a shift register and go to START on the next edge.
REQ-023 START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-024 DATA: drive DATA_BITS bits LSB first, each for CLKS_PER_BIT cycles; then go to PARITY if PARITY!=0, else to STOP.
REQ-025 PARITY: drive the XOR of the data bits for even parity, or its inverse for odd parity, for CLKS_PER_BIT cycles.
REQ-026 STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles; o_TxDone SHALL be 1 on the final cycle.
REQ-027 At the end of STOP with the FIFO non-empty, pop and enter START with no idle cycle (back-to-back frames); otherwise go to IDLE.
REQ-028 o_TxBusy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-029 A push into an empty FIFO while IDLE SHALL give o_TxSerial=0 within 2 cycles of the push edge.
REQ-030 A word held in the shift register SHALL be unaffected by later FIFO writes.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; full when count=FIFO_DEPTH, empty when count=0.

Reset
REQ-032 On i_Reset=1, immediately and independent of the clock: FSM=IDLE, FIFO emptied, o_TxSerial=1, o_TxBusy=0, o_TxDone=0, o_Overflow=0, o_FifoCount=0, o_TxReady=1.
REQ-033 Reset during a frame SHALL abort it with the line high; there SHALL be no partial stop bit or done pulse.

Structure
REQ-034 Package uart_pkg SHALL hold the PARITY encoding constants, the FSM state encoding, and a CLKS_PER_BIT calculation function shared with uart_rx.
REQ-035 The buffer SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH; ports for push, pop, full, empty and count).

Verification
REQ-036 Defaults, write 0x55: the line shows start 0, then bits 1010_1010, then stop 1; each bit is 434 clocks; o_TxDone pulses once after 4340 clocks.
REQ-037 PARITY=1 sends 0x07 with parity bit 1; PARITY=2 sends 0x07 with parity bit 0; STOP_BITS=2 gives a stop high for 868 clocks.
REQ-038 Burst of 20 writes with FIFO_DEPTH=16 while busy: o_TxReady drops at count 16, the extra writes pulse o_Overflow, and the frames decoded by uart_rx match the accepted words in order with no gap between frames.
REQ-039 DATA_BITS=5, write 0x1F: the frame is 7 bit times (start, 5 data, 1 stop), and the upper data input bits are ignored.
REQ-040 Assert i_Reset in the middle of a DATA bit: o_TxSerial=1 without waiting for a clock edge, o_FifoCount=0, and no o_TxDone; after release, a new write of 0xA5 transmits correctly.
